// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states,
// instruction field layout and an encoder helper.
package alu_op_sequencer_pkg;

  localparam int DATA_W  = 32;
  localparam int NREGS   = 8;
  localparam int IMM_W   = 3;
  localparam int INSTR_W = 16;

  // Instruction field positions: [15:13] op, [12:10] rd, [9:7] rs1,
  // [6:4] rs2, [3] use_imm, [2:0] imm
  localparam int OP_LSB      = 13;
  localparam int RD_LSB      = 10;
  localparam int RS1_LSB     = 7;
  localparam int RS2_LSB     = 4;
  localparam int USE_IMM_BIT = 3;
  localparam int IMM_LSB     = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_NOT = 3'b010,
    ALU_SHL = 3'b011,
    ALU_SHR = 3'b100,
    ALU_AND = 3'b101,
    ALU_OR  = 3'b110,
    ALU_ONE = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Packed layout mirrors the bit positions above, MSB first
  typedef struct packed {
    alu_op_t    op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       use_imm;
    logic [2:0] imm;
  } instr_t;

  function automatic logic [INSTR_W-1:0] make_instr(
    input logic [2:0] op,
    input logic [2:0] rd,
    input logic [2:0] rs1,
    input logic [2:0] rs2,
    input logic       use_imm,
    input logic [2:0] imm
  );
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_LSB +: 3]     = op;
    w[RD_LSB +: 3]     = rd;
    w[RS1_LSB +: 3]    = rs1;
    w[RS2_LSB +: 3]    = rs2;
    w[USE_IMM_BIT]     = use_imm;
    w[IMM_LSB +: 3]    = imm;
    return w;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction valid/ready channel between the instruction source and the
// sequencer.
interface alu_op_sequencer_if;
  logic                                   instr_valid;
  logic                                   instr_ready;
  logic [alu_op_sequencer_pkg::INSTR_W-1:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/alu_op_sequencer_reg_file_8x32.sv
// Register file with two operand read ports, a host observation port and a
// write path where writeback takes priority over the host on the same entry.
module reg_file_8x32 #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic [DATA_W-1:0] host_rd_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data
);

  logic [DATA_W-1:0] regs_reg [NREGS];
  logic [NREGS-1:0]  wb_hit;
  logic [NREGS-1:0]  host_hit;

  // Entry 0 never matches, so r0 is never written
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_sel
      assign wb_hit[gi]   = (gi != 0) && wb_en      && (wb_addr      == ADDR_W'(gi));
      assign host_hit[gi] = (gi != 0) && host_wr_en && (host_wr_addr == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (rst) begin
        regs_reg[i] <= '0;
      end else if (wb_hit[i]) begin
        regs_reg[i] <= wb_data;
      end else if (host_hit[i]) begin
        regs_reg[i] <= host_wr_data;
      end
    end
  end

  assign rd_data_a    = (rd_addr_a    == '0) ? '0 : regs_reg[rd_addr_a];
  assign rd_data_b    = (rd_addr_b    == '0) ? '0 : regs_reg[rd_addr_b];
  assign host_rd_data = (host_rd_addr == '0) ? '0 : regs_reg[host_rd_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/writeback controller: accepts one instruction, drives the external
// ALU for one cycle, then writes the sampled result back (IDLE->EXEC->WB).
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int IMM_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  alu_op_sequencer_if.slave          instr_bus,
  output logic [DATA_W-1:0]          alu_operand_1,
  output logic [DATA_W-1:0]          alu_operand_2,
  output logic [2:0]                 alu_control,
  input  logic [DATA_W-1:0]          alu_resultado,
  input  logic                       host_wr_en,
  input  logic [$clog2(NREGS)-1:0]   host_wr_addr,
  input  logic [DATA_W-1:0]          host_wr_data,
  input  logic [$clog2(NREGS)-1:0]   host_rd_addr,
  output logic [DATA_W-1:0]          host_rd_data,
  output logic                       done,
  output logic [DATA_W-1:0]          done_value
);

  localparam int ADDR_W = $clog2(NREGS);

  state_t            state_reg, state_next;
  instr_t            instr_word;
  logic              ready_int;
  logic              accept;
  logic              wb_en;
  logic [DATA_W-1:0] rs1_data, rs2_data, imm_ext;
  logic [DATA_W-1:0] op1_reg, op2_reg, result_reg;
  alu_op_t           ctrl_reg;
  logic [ADDR_W-1:0] rd_reg;

  assign instr_word = instr_t'(instr_bus.instr);
  assign accept     = instr_bus.instr_valid && ready_int;
  assign imm_ext    = {{(DATA_W-IMM_W){1'b0}}, instr_word.imm[IMM_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_WB;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_int = 1'b0;
    done      = 1'b0;
    wb_en     = 1'b0;
    case (state_reg)
      ST_IDLE: ready_int = 1'b1;
      ST_WB: begin
        done  = 1'b1;
        wb_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign instr_bus.instr_ready = ready_int;

  // Operands are frozen at accept, so later host writes cannot disturb them;
  // result_reg doubles as done_value and holds until the next EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_reg    <= '0;
      op2_reg    <= '0;
      ctrl_reg   <= ALU_ADD;
      rd_reg     <= '0;
      result_reg <= '0;
    end else begin
      if (accept) begin
        op1_reg  <= rs1_data;
        op2_reg  <= instr_word.use_imm ? imm_ext : rs2_data;
        ctrl_reg <= instr_word.op;
        rd_reg   <= instr_word.rd;
      end
      if (state_reg == ST_EXEC) begin
        result_reg <= alu_resultado;
      end
    end
  end

  assign alu_operand_1 = op1_reg;
  assign alu_operand_2 = op2_reg;
  assign alu_control   = ctrl_reg;
  assign done_value    = result_reg;

  reg_file_8x32 #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_reg_file (
    .clk          (clk),
    .rst          (rst),
    .rd_addr_a    (instr_word.rs1),
    .rd_data_a    (rs1_data),
    .rd_addr_b    (instr_word.rs2),
    .rd_data_b    (rs2_data),
    .host_rd_addr (host_rd_addr),
    .host_rd_data (host_rd_data),
    .wb_en        (wb_en),
    .wb_addr      (rd_reg),
    .wb_data      (result_reg),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data)
  );

endmodule
